// File: rtl/lpf_iir1_tdm_if.sv
// Frame-in / channel-out signal bundle for the time-multiplexed IIR lowpass.
// The framer drives the master side; the filter sits on the slave side.
interface lpf_iir1_tdm_if #(
  parameter int NCH    = 4,
  parameter int DATA_W = 9
);
  localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1;

  logic                    sample_en;
  logic [NCH*DATA_W-1:0]   in_data;
  logic                    bypass;
  logic [NCH*DATA_W-1:0]   out_data;
  logic                    ch_valid;
  logic [CH_W-1:0]         ch_idx;
  logic [DATA_W-1:0]       ch_data;
  logic                    frame_done;
  logic                    busy;
  logic                    overrun;

  modport master (
    output sample_en, in_data, bypass,
    input  out_data, ch_valid, ch_idx, ch_data, frame_done, busy, overrun
  );

  modport slave (
    input  sample_en, in_data, bypass,
    output out_data, ch_valid, ch_idx, ch_data, frame_done, busy, overrun
  );
endinterface

// File: rtl/lpf_iir1_tdm.sv
// Multi-channel first-order IIR lowpass, one shared datapath walking the
// channels serially after each frame strobe. Unity DC gain, pole 1-2^-SHIFT.
module lpf_iir1_tdm #(
  parameter int NCH    = 4,
  parameter int DATA_W = 9,
  parameter int SHIFT  = 3
) (
  input  logic           clk,
  input  logic           rst,
  lpf_iir1_tdm_if.slave  bus
);
  localparam int CH_W   = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int ACC_W  = DATA_W + SHIFT + 1;
  localparam int WIDE_W = ACC_W + 2;
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NCH - 1);

  typedef enum logic {IDLE, RUN} state_e;

  state_e                          state_q, state_d;
  logic [CH_W-1:0]                 ch_q, ch_d;
  logic                            capture, process, last;

  logic [NCH-1:0][DATA_W-1:0]      in_buf_q;
  logic                            byp_q;
  logic [NCH-1:0][ACC_W-1:0]       acc_q;
  logic [NCH-1:0][DATA_W-1:0]      xprev_q;
  logic [NCH-1:0][DATA_W-1:0]      out_q;
  logic                            ch_valid_q, frame_done_q, overrun_q;
  logic [CH_W-1:0]                 ch_idx_q;
  logic [DATA_W-1:0]               ch_data_q;

  logic [ACC_W-1:0]                cur_acc, acc_n;
  logic [DATA_W-1:0]               cur_x, cur_xp, y;
  logic signed [WIDE_W-1:0]        acc_w, x_w, xp_w, acc_wide;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ch_q    <= '0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    capture = 1'b0;
    process = 1'b0;
    last    = (ch_q == LAST_CH);
    case (state_q)
      IDLE: begin
        if (bus.sample_en) begin
          capture = 1'b1;
          ch_d    = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        process = 1'b1;
        if (last) state_d = IDLE;
        else      ch_d    = ch_q + CH_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  // Evaluated two bits wider than the accumulator so a wrap would be visible.
  always_comb begin
    cur_acc  = acc_q[ch_q];
    cur_x    = in_buf_q[ch_q];
    cur_xp   = xprev_q[ch_q];
    acc_w    = {{(WIDE_W-ACC_W){cur_acc[ACC_W-1]}}, cur_acc};
    x_w      = {{(WIDE_W-DATA_W){cur_x[DATA_W-1]}}, cur_x};
    xp_w     = {{(WIDE_W-DATA_W){cur_xp[DATA_W-1]}}, cur_xp};
    acc_wide = acc_w - (acc_w >>> SHIFT) + x_w + xp_w;
    acc_n    = acc_wide[ACC_W-1:0];
    y        = byp_q ? cur_x : acc_n[ACC_W-1:SHIFT+1];
    if (process)
      assert (acc_wide[WIDE_W-1:ACC_W-1] == '0 || acc_wide[WIDE_W-1:ACC_W-1] == '1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_buf_q     <= '0;
      byp_q        <= 1'b0;
      acc_q        <= '0;
      xprev_q      <= '0;
      out_q        <= '0;
      ch_valid_q   <= 1'b0;
      frame_done_q <= 1'b0;
      ch_idx_q     <= '0;
      ch_data_q    <= '0;
      overrun_q    <= 1'b0;
    end else begin
      if (capture) begin
        in_buf_q <= bus.in_data;
        byp_q    <= bus.bypass;
      end
      if (bus.sample_en && state_q == RUN) overrun_q <= 1'b1;
      ch_valid_q   <= process;
      frame_done_q <= process && last;
      // Bypass still advances the filter state so un-bypassing is seamless.
      if (process) begin
        acc_q[ch_q]   <= acc_n;
        xprev_q[ch_q] <= cur_x;
        out_q[ch_q]   <= y;
        ch_data_q     <= y;
        ch_idx_q      <= ch_q;
      end
    end
  end

  assign bus.out_data   = out_q;
  assign bus.ch_valid   = ch_valid_q;
  assign bus.ch_idx     = ch_idx_q;
  assign bus.ch_data    = ch_data_q;
  assign bus.frame_done = frame_done_q;
  assign bus.busy       = (state_q == RUN);
  assign bus.overrun    = overrun_q;
endmodule

// File: tb/tb_lpf_iir1_tdm.sv
// Scoreboard bench for lpf_iir1_tdm: per-channel reference model, cycle-exact
// result timing, busy/overrun tracking and directed settling cases.
module tb_lpf_iir1_tdm;
  localparam int NCH    = 4;
  localparam int DATA_W = 9;
  localparam int SHIFT  = 3;

  typedef struct { int cyc; int idx; int data; int fd; } exp_t;
  typedef logic [NCH-1:0][DATA_W-1:0] frame_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lpf_iir1_tdm_if #(.NCH(NCH), .DATA_W(DATA_W)) bus();
  lpf_iir1_tdm #(.NCH(NCH), .DATA_W(DATA_W), .SHIFT(SHIFT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int   cyc = 0;
  int   n_vec = 0, n_err = 0;
  int   b_lo = 1, b_hi = 0;
  int   ovr_from = 32'h7fffffff;
  int   macc [NCH];
  int   mxp  [NCH];
  exp_t q [$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int slice(input int c);
    logic [DATA_W-1:0] v;
    v = bus.out_data[c*DATA_W +: DATA_W];
    return int'($signed(v));
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    q.delete();
    for (int c = 0; c < NCH; c++) begin
      macc[c] = 0;
      mxp[c]  = 0;
    end
    b_lo = 1; b_hi = 0; ovr_from = 32'h7fffffff;
    tick; tick;
    rst = 1'b0;
    tick;
  endtask

  // Drives a one-cycle strobe; the model decides acceptance from its own busy window.
  task automatic strobe(input frame_t xs, input bit byp);
    exp_t e;
    int   x, a;
    bus.sample_en = 1'b1;
    bus.in_data   = xs;
    bus.bypass    = byp;
    if (cyc >= b_lo && cyc <= b_hi) begin
      if (ovr_from > cyc + 1) ovr_from = cyc + 1;
    end else begin
      b_lo = cyc + 1;
      b_hi = cyc + NCH;
      for (int c = 0; c < NCH; c++) begin
        x       = int'($signed(xs[c]));
        a       = macc[c] - (macc[c] >>> SHIFT) + x + mxp[c];
        macc[c] = a;
        mxp[c]  = x;
        e.cyc   = cyc + c + 2;
        e.idx   = c;
        e.data  = byp ? x : (a >>> (SHIFT + 1));
        e.fd    = (c == NCH - 1) ? 1 : 0;
        q.push_back(e);
      end
    end
    tick;
    bus.sample_en = 1'b0;
    bus.in_data   = (NCH*DATA_W)'({$urandom, $urandom});
    bus.bypass    = 1'($urandom);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      chk("busy", int'(bus.busy), int'(cyc >= b_lo && cyc <= b_hi));
      chk("overrun", int'(bus.overrun), int'(cyc >= ovr_from));
      while (q.size() != 0 && q[0].cyc < cyc) begin
        chk("missed_result_cyc", cyc, q[0].cyc);
        void'(q.pop_front());
      end
      if (bus.ch_valid) begin
        if (q.size() == 0) chk("spurious_valid", 1, 0);
        else begin
          e = q.pop_front();
          chk("valid_cyc", cyc, e.cyc);
          chk("ch_idx", int'(bus.ch_idx), e.idx);
          chk("ch_data", int'($signed(bus.ch_data)), e.data);
          chk("frame_done", int'(bus.frame_done), e.fd);
          chk("out_slice", slice(e.idx), e.data);
        end
      end else if (bus.frame_done) begin
        chk("frame_done_no_valid", 1, 0);
      end
    end
  end

  initial begin
    frame_t xs, xs2;
    int     seq [3];
    seq = '{6, 18, 28};
    bus.sample_en = 1'b0;
    bus.in_data   = '0;
    bus.bypass    = 1'b0;

    // reset state
    do_reset;
    repeat (3) tick;
    for (int c = 0; c < NCH; c++) chk("rst_out", slice(c), 0);
    chk("rst_valid", int'(bus.ch_valid), 0);
    chk("rst_fdone", int'(bus.frame_done), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_ovr", int'(bus.overrun), 0);

    // step response / settling at min frame period
    xs[0] = 9'd100; xs[1] = 9'h100; xs[2] = 9'd255; xs[3] = '0;
    for (int f = 0; f < 120; f++) begin
      strobe(xs, 1'b0);
      repeat (4) tick;
      if (f < 3) chk("ch0_step", slice(0), seq[f]);
      chk("ch3_iso", slice(3), 0);
    end
    tick;
    chk("ch0_settle", slice(0), 100);
    chk("ch1_settle", slice(1), -256);
    chk("ch2_settle", slice(2), 255);
    chk("settle_ovr", int'(bus.overrun), 0);

    // bypass then resume from internal state
    do_reset;
    strobe(xs, 1'b1);
    repeat (4) tick;
    chk("byp_ch0", slice(0), 100);
    chk("byp_ch1", slice(1), -256);
    strobe(xs, 1'b0);
    repeat (4) tick;
    strobe(xs, 1'b0);
    repeat (4) tick;
    chk("byp_resume", slice(0), 28);

    // random back-to-back frames against the model
    do_reset;
    for (int f = 0; f < 1000; f++) begin
      frame_t r;
      for (int c = 0; c < NCH; c++) r[c] = DATA_W'($urandom);
      strobe(r, ($urandom_range(0, 7) == 0));
      repeat (4) tick;
    end
    repeat (2) tick;
    chk("rand_ovr", int'(bus.overrun), 0);

    // strobe while busy is dropped; strobe as busy falls is taken
    do_reset;
    for (int c = 0; c < NCH; c++) xs2[c] = '1;
    strobe(xs, 1'b0);
    tick;
    strobe(xs2, 1'b0);
    tick; tick;
    strobe(xs, 1'b0);
    repeat (4) tick;
    chk("ovr_set", int'(bus.overrun), 1);
    repeat (10) tick;
    chk("ovr_sticky", int'(bus.overrun), 1);

    // reset in the middle of a frame
    do_reset;
    strobe(xs, 1'b0);
    tick;
    do_reset;
    repeat (6) tick;
    for (int c = 0; c < NCH; c++) chk("midrst_out", slice(c), 0);
    chk("midrst_busy", int'(bus.busy), 0);
    chk("midrst_ovr", int'(bus.overrun), 0);
    strobe(xs, 1'b0);
    repeat (4) tick;
    chk("midrst_fresh", slice(0), 6);

    for (int i = 0; i < 20 && q.size() != 0; i++) tick;
    chk("drain", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
